// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC capture path: cycle-type fields,
// queued entry layout, record length and the serializer state encoding.
package lpc_pkg;

  localparam logic [1:0] CYC_IO  = 2'b00;
  localparam logic [1:0] CYC_MEM = 2'b01;

  localparam int         REC_LEN  = 7;
  localparam logic [2:0] LAST_IDX = 3'(REC_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  cyctype;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        ovf;
  } cap_entry_t;

  // Byte idx of the serial record for one captured cycle.
  function automatic logic [7:0] rec_byte(input cap_entry_t e,
                                          input logic [2:0] idx,
                                          input logic [7:0] sync);
    logic [7:0] b;
    b = '0;
    case (idx)
      3'd0: b = sync;
      3'd1: b = {e.cyctype, 3'b000, e.ovf};
      3'd2: b = e.addr[31:24];
      3'd3: b = e.addr[23:16];
      3'd4: b = e.addr[15:8];
      3'd5: b = e.addr[7:0];
      3'd6: b = e.data;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpc_fifo.sv
// Synchronous FIFO with combinational head output; a write is accepted while
// full as long as a read happens on the same edge.
module lpc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign level_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lpc_capture_ctrl.sv
// Captures decoded LPC cycles into a queue and serializes each one as a
// 7-byte record (sync, type/ovf, address MSB first, data) over a valid/ready link.
module lpc_capture_ctrl
  import lpc_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        cap_strobe,
  input  logic [3:0]  cap_cyctype,
  input  logic [31:0] cap_addr,
  input  logic [7:0]  cap_data,
  input  logic        enable,
  input  logic        io_only,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int EW = $bits(cap_entry_t);

  logic                        strobe_q;
  logic                        ovf_pending_q;
  logic [7:0]                  drop_count_q;
  state_e                      state_q;
  logic [2:0]                  idx_q;
  cap_entry_t                  shadow_q;
  logic                        tx_valid_q;
  logic [7:0]                  tx_data_q;

  logic                        cap_event;
  logic                        qualified;
  logic                        push;
  logic                        pop;
  logic                        drop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  cap_entry_t                  push_entry;
  logic [EW-1:0]               head_bits;
  cap_entry_t                  head_entry;

  assign cap_event  = cap_strobe && !strobe_q;
  assign qualified  = cap_event && enable && (!io_only || cap_cyctype[3:2] == CYC_IO);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign push       = qualified && (!fifo_full || pop);
  assign drop       = qualified && fifo_full && !pop;
  assign push_entry = '{cyctype: cap_cyctype, addr: cap_addr, data: cap_data, ovf: ovf_pending_q};
  assign head_entry = cap_entry_t'(head_bits);

  lpc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (lpc_clock),
    .rst_n     (lpc_reset),
    .wr_en_i   (push),
    .wr_data_i (push_entry),
    .rd_en_i   (pop),
    .rd_data_o (head_bits),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // strobe_q resets high so a strobe already asserted at release is not an edge.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      strobe_q      <= 1'b1;
      ovf_pending_q <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      strobe_q <= cap_strobe;
      if (drop) begin
        ovf_pending_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end else if (push) begin
        ovf_pending_q <= 1'b0;
      end
    end
  end

  // The first SEND cycle only primes the output register, so tx_valid trails the pop by one clock.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shadow_q <= head_entry;
            idx_q    <= '0;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= rec_byte(shadow_q, idx_q, SYNC_BYTE);
          end else if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= rec_byte(shadow_q, idx_q + 3'd1, SYNC_BYTE);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign drop_count = drop_count_q;
  assign busy       = (fifo_level != '0) || (state_q == ST_SEND);

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// Directed self-checking bench for lpc_capture_ctrl: latency, filtering,
// overflow/ovf flag, back-pressure stability, held strobe and reset mid-record.
module tb_lpc_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cap_strobe;
  logic [3:0]  cap_cyctype;
  logic [31:0] cap_addr;
  logic [7:0]  cap_data;
  logic        enable;
  logic        io_only;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  drop_count;
  logic        busy;

  int n_pass;
  int n_total;

  logic [7:0] rx_q[$];
  logic       hold_chk;
  logic [7:0] held_data;

  lpc_capture_ctrl #(
    .FIFO_DEPTH (8),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .lpc_clock   (clk),
    .lpc_reset   (rst_n),
    .cap_strobe  (cap_strobe),
    .cap_cyctype (cap_cyctype),
    .cap_addr    (cap_addr),
    .cap_data    (cap_data),
    .enable      (enable),
    .io_only     (io_only),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte monitor: logs every handshake and checks that a stalled byte holds.
  always @(posedge clk) begin
    if (hold_chk) begin
      n_total++;
      if (tx_valid !== 1'b1 || tx_data !== held_data)
        $display("FAIL hold_stable: got valid=%b data=%02h, need valid=1 data=%02h",
                 tx_valid, tx_data, held_data);
      else
        n_pass++;
    end
    hold_chk  = rst_n && tx_valid && !tx_ready;
    held_data = tx_data;
    if (rst_n && tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      $display("byte %0d accepted: %02h", rx_q.size() - 1, tx_data);
    end
  end

  always @(negedge rst_n) hold_chk = 1'b0;

  task automatic do_capture(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    cap_strobe  = 1'b1;
    cap_cyctype = ct;
    cap_addr    = a;
    cap_data    = d;
    @(negedge clk);
    cap_strobe  = 1'b0;
  endtask

  task automatic wait_bytes(input int count, input int budget);
    for (int i = 0; i < budget && rx_q.size() < count; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cap_strobe = 1'b0; cap_cyctype = '0; cap_addr = '0; cap_data = '0;
    enable = 1'b1; io_only = 1'b0; tx_ready = 1'b1; hold_chk = 1'b0; held_data = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'h00 || tx_data !== 8'h00)
      $display("FAIL reset_state: got valid=%b busy=%b drop=%02h data=%02h, need 0 0 00 00",
               tx_valid, busy, drop_count, tx_data);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_reset_idle: got valid=%b busy=%b, need 0 0", tx_valid, busy);
    else n_pass++;
  endtask

  task automatic test_single;
    logic [7:0] exp_b [7];
    exp_b = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h80, 8'h3C};
    rx_q.delete();
    tx_ready = 1'b1;
    @(negedge clk);
    cap_strobe = 1'b1; cap_cyctype = 4'h2; cap_addr = 32'h0000_0080; cap_data = 8'h3C;
    @(negedge clk);  // capture edge N has passed
    cap_strobe = 1'b0;
    n_total++;
    if (tx_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL lat_n: got valid=%b busy=%b, need 0 1", tx_valid, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (tx_valid !== 1'b0)
      $display("FAIL lat_n1: got valid=%b, need 0", tx_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL lat_n2: got valid=%b data=%02h, need 1 A5", tx_valid, tx_data);
    else n_pass++;
    wait_bytes(7, 40);
    repeat (5) @(negedge clk);
    n_total++;
    if (rx_q.size() != 7)
      $display("FAIL single_count: got %0d bytes, need 7", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        n_total++;
        if (rx_q[i] !== exp_b[i])
          $display("FAIL single_byte%0d: got %02h, need %02h", i, rx_q[i], exp_b[i]);
        else n_pass++;
      end
    end
    n_total++;
    if (busy !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL single_idle: got busy=%b valid=%b, need 0 0", busy, tx_valid);
    else n_pass++;
  endtask

  task automatic test_filter;
    rx_q.delete();
    io_only = 1'b1;
    do_capture(4'h6, 32'hFEED_0000, 8'h11);
    repeat (10) @(negedge clk);
    n_total++;
    if (rx_q.size() != 0 || drop_count !== 8'h00 || busy !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL filter_mem: got bytes=%0d drop=%02h busy=%b valid=%b, need 0 00 0 0",
               rx_q.size(), drop_count, busy, tx_valid);
    else n_pass++;
    io_only = 1'b0;
    enable  = 1'b0;
    do_capture(4'h2, 32'h0000_0060, 8'h22);
    repeat (10) @(negedge clk);
    n_total++;
    if (rx_q.size() != 0 || drop_count !== 8'h00 || busy !== 1'b0)
      $display("FAIL filter_disabled: got bytes=%0d drop=%02h busy=%b, need 0 00 0",
               rx_q.size(), drop_count, busy);
    else n_pass++;
    enable  = 1'b1;
    io_only = 1'b1;
    do_capture(4'h3, 32'h0000_0064, 8'h5A);
    wait_bytes(7, 40);
    n_total++;
    if (rx_q.size() != 7)
      $display("FAIL filter_io_pass: got %0d bytes, need 7", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 7) begin
      n_total++;
      if (rx_q[1] !== 8'h30 || rx_q[6] !== 8'h5A)
        $display("FAIL filter_io_bytes: got b1=%02h b6=%02h, need 30 5A", rx_q[1], rx_q[6]);
      else n_pass++;
    end
    io_only = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_toggle;
    rx_q.delete();
    tx_ready = 1'b0;
    do_capture(4'h2, 32'hDEAD_BEEF, 8'h77);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_total++;
    if (rx_q.size() != 7)
      $display("FAIL toggle_count: got %0d bytes, need 7", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 7) begin
      n_total++;
      if (rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h20 || rx_q[2] !== 8'hDE || rx_q[3] !== 8'hAD ||
          rx_q[4] !== 8'hBE || rx_q[5] !== 8'hEF || rx_q[6] !== 8'h77)
        $display("FAIL toggle_bytes: got %02h %02h %02h %02h %02h %02h %02h, need A5 20 DE AD BE EF 77",
                 rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4], rx_q[5], rx_q[6]);
      else n_pass++;
    end
  endtask

  task automatic test_held_strobe;
    rx_q.delete();
    tx_ready = 1'b1;
    @(negedge clk);
    cap_strobe = 1'b1; cap_cyctype = 4'h0; cap_addr = 32'h0000_03F8; cap_data = 8'h41;
    repeat (20) @(negedge clk);
    cap_strobe = 1'b0;
    repeat (30) @(negedge clk);
    n_total++;
    if (rx_q.size() != 7)
      $display("FAIL held_strobe_count: got %0d bytes, need 7", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 7) begin
      n_total++;
      if (rx_q[1] !== 8'h00 || rx_q[4] !== 8'h03 || rx_q[5] !== 8'hF8 || rx_q[6] !== 8'h41)
        $display("FAIL held_strobe_bytes: got b1=%02h b4=%02h b5=%02h b6=%02h, need 00 03 F8 41",
                 rx_q[1], rx_q[4], rx_q[5], rx_q[6]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    rx_q.delete();
    tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) do_capture(4'h2, 32'h1000_0000 + 32'(i), 8'(i));
    @(negedge clk);
    n_total++;
    if (drop_count !== 8'h01)
      $display("FAIL ovf_drop_count: got %02h, need 01", drop_count);
    else n_pass++;
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1)
      $display("FAIL ovf_stalled: got valid=%b data=%02h busy=%b, need 1 A5 1", tx_valid, tx_data, busy);
    else n_pass++;
    tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    do_capture(4'h2, 32'h0000_000B, 8'hBB);
    wait_bytes(70, 400);
    repeat (5) @(negedge clk);
    n_total++;
    if (rx_q.size() != 70 || drop_count !== 8'h01)
      $display("FAIL ovf_total: got bytes=%0d drop=%02h, need 70 01", rx_q.size(), drop_count);
    else n_pass++;
    if (rx_q.size() == 70) begin
      for (int r = 0; r < 9; r++) begin
        n_total++;
        if (rx_q[r*7] !== 8'hA5 || rx_q[r*7+1] !== 8'h20 || rx_q[r*7+5] !== 8'(r+1) ||
            rx_q[r*7+6] !== 8'(r+1))
          $display("FAIL ovf_rec%0d: got %02h %02h %02h %02h, need A5 20 %02h %02h", r,
                   rx_q[r*7], rx_q[r*7+1], rx_q[r*7+5], rx_q[r*7+6], 8'(r+1), 8'(r+1));
        else n_pass++;
      end
      n_total++;
      if (rx_q[63] !== 8'hA5 || rx_q[64] !== 8'h21 || rx_q[68] !== 8'h0B || rx_q[69] !== 8'hBB)
        $display("FAIL ovf_flag_rec: got %02h %02h %02h %02h, need A5 21 0B BB",
                 rx_q[63], rx_q[64], rx_q[68], rx_q[69]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    rx_q.delete();
    tx_ready = 1'b0;
    do_capture(4'h3, 32'h1234_5678, 8'h99);
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() < 3; i++) @(negedge clk);
    tx_ready = 1'b0;
    n_total++;
    if (rx_q.size() != 3 || tx_valid !== 1'b1 || tx_data !== 8'h34)
      $display("FAIL mid_idx3: got bytes=%0d valid=%b data=%02h, need 3 1 34",
               rx_q.size(), tx_valid, tx_data);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    cap_strobe = 1'b1;
    #1;
    n_total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || drop_count !== 8'h00)
      $display("FAIL mid_async_reset: got valid=%b busy=%b data=%02h drop=%02h, need 0 0 00 00",
               tx_valid, busy, tx_data, drop_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if (rx_q.size() != 3 || tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_no_resume: got bytes=%0d valid=%b busy=%b, need 3 0 0",
               rx_q.size(), tx_valid, busy);
    else n_pass++;
    cap_strobe = 1'b0;
    do_capture(4'h2, 32'h0000_0080, 8'h3C);
    wait_bytes(10, 40);
    n_total++;
    if (rx_q.size() != 10)
      $display("FAIL mid_new_record: got %0d bytes, need 10", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 10) begin
      n_total++;
      if (rx_q[3] !== 8'hA5 || rx_q[4] !== 8'h20 || rx_q[9] !== 8'h3C)
        $display("FAIL mid_new_bytes: got %02h %02h %02h, need A5 20 3C", rx_q[3], rx_q[4], rx_q[9]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_filter();
    test_toggle();
    test_held_strobe();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
